// File: rtl/mem_arb_ctrl.sv
// Single-port word memory shared by NUM_CH requesters through a round-robin arbiter.
// Byte-enabled writes, fixed read latency, one outstanding read per channel, out-of-range flagging.
module mem_arb_ctrl #(
   parameter  int ADDR_WIDTH = 8,
   parameter  int DATA_WIDTH = 16,
   parameter  int DEPTH      = 256,
   parameter  int NUM_CH     = 2,
   parameter  int RD_LAT     = 1,
   localparam int BE_WIDTH   = DATA_WIDTH / 8
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [NUM_CH-1:0]                    req_vld_i,
   input  logic [NUM_CH-1:0]                    req_wr_i,
   input  logic [NUM_CH-1:0][ADDR_WIDTH-1:0]    req_addr_i,
   input  logic [NUM_CH-1:0][DATA_WIDTH-1:0]    req_wdata_i,
   input  logic [NUM_CH-1:0][BE_WIDTH-1:0]      req_be_i,
   output logic [NUM_CH-1:0]                    req_rdy_o,
   output logic [NUM_CH-1:0]                    rsp_vld_o,
   output logic [NUM_CH-1:0][DATA_WIDTH-1:0]    rsp_rdata_o,
   output logic [NUM_CH-1:0]                    rsp_err_o,
   input  logic [NUM_CH-1:0]                    rsp_rdy_i
);

   localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   // Arbitration
   logic [CH_W-1:0]   rr_q, rr_d;
   logic [NUM_CH-1:0] rd_busy_q, rd_busy_d;
   logic [NUM_CH-1:0] elig, gnt;
   logic [CH_W-1:0]   gnt_idx, scan;
   logic              gnt_any;

   // Selected request payload
   logic                  sel_wr;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0] sel_wdata;
   logic [BE_WIDTH-1:0]   sel_be;
   logic [IDX_W-1:0]      sel_idx;
   logic                  sel_in_range;
   logic                  wr_en, rd_acc;
   logic [DATA_WIDTH-1:0] rd_word;

   // Per-channel response state
   logic [NUM_CH-1:0]                 rsp_vld_q, rsp_vld_d;
   logic [NUM_CH-1:0]                 rsp_err_q, rsp_err_d;
   logic [NUM_CH-1:0][DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
   logic [NUM_CH-1:0]                 pend_q, pend_d;
   logic [NUM_CH-1:0][1:0]            cnt_q, cnt_d;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   always_comb begin
      // NOTE: every variable gets a default before any branch so no latch is inferred.
      elig    = req_vld_i & (req_wr_i | ~rd_busy_q) & {NUM_CH{~rst}};
      gnt     = '0;
      gnt_idx = '0;
      gnt_any = 1'b0;
      scan    = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         scan = CH_W'((int'(rr_q) + i) % NUM_CH);
         if (!gnt_any && elig[scan]) begin
            gnt_any   = 1'b1;
            gnt_idx   = scan;
            gnt[scan] = 1'b1;
         end
      end
      rr_d = gnt_any ? CH_W'((int'(gnt_idx) + 1) % NUM_CH) : rr_q;
   end

   assign req_rdy_o = gnt;

   always_comb begin
      sel_wr       = req_wr_i[gnt_idx];
      sel_addr     = req_addr_i[gnt_idx];
      sel_wdata    = req_wdata_i[gnt_idx];
      sel_be       = req_be_i[gnt_idx];
      sel_idx      = sel_addr[IDX_W-1:0];
      sel_in_range = int'(sel_addr) < DEPTH;
      wr_en        = gnt_any & sel_wr & sel_in_range;
      rd_acc       = gnt_any & ~sel_wr;
      rd_word      = sel_in_range ? mem_q[sel_idx] : '0;
   end

   // Read data is captured at the accept edge, so later writes cannot disturb it.
   always_comb begin
      rsp_vld_d   = rsp_vld_q;
      rsp_err_d   = rsp_err_q;
      rsp_rdata_d = rsp_rdata_q;
      pend_d      = pend_q;
      cnt_d       = cnt_q;
      rd_busy_d   = rd_busy_q;
      for (int c = 0; c < NUM_CH; c++) begin
         if (rsp_vld_q[c] && rsp_rdy_i[c]) begin
            rsp_vld_d[c] = 1'b0;
            rd_busy_d[c] = 1'b0;
         end
         if (pend_q[c]) begin
            if (cnt_q[c] == 2'd0) begin
               rsp_vld_d[c] = 1'b1;
               pend_d[c]    = 1'b0;
            end else begin
               cnt_d[c] = cnt_q[c] - 2'd1;
            end
         end
         if (rd_acc && gnt[c]) begin
            rd_busy_d[c]   = 1'b1;
            pend_d[c]      = 1'b1;
            cnt_d[c]       = 2'(RD_LAT - 1);
            rsp_rdata_d[c] = rd_word;
            rsp_err_d[c]   = ~sel_in_range;
         end
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so all flops update together.
      if (rst) begin
         rr_q        <= '0;
         rd_busy_q   <= '0;
         rsp_vld_q   <= '0;
         rsp_err_q   <= '0;
         rsp_rdata_q <= '0;
         pend_q      <= '0;
         cnt_q       <= '0;
      end else begin
         rr_q        <= rr_d;
         rd_busy_q   <= rd_busy_d;
         rsp_vld_q   <= rsp_vld_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
         pend_q      <= pend_d;
         cnt_q       <= cnt_d;
      end
   end

   // NOTE: the storage array has no reset so it can map onto a RAM macro.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int b = 0; b < BE_WIDTH; b++) begin
            if (sel_be[b]) mem_q[sel_idx][8*b +: 8] <= sel_wdata[8*b +: 8];
         end
      end
   end

   assign rsp_vld_o   = rsp_vld_q;
   assign rsp_err_o   = rsp_err_q;
   assign rsp_rdata_o = rsp_rdata_q;

endmodule

// File: tb/tb_mem_arb_ctrl.sv
// Directed bench for mem_arb_ctrl: instance 0 has DEPTH=200/RD_LAT=1, instance 1 has
// DEPTH=256/RD_LAT=3; expected values are written out by hand in each test.
module tb_mem_arb_ctrl;

   localparam int AW = 8;
   localparam int DW = 16;
   localparam int NC = 2;
   localparam int BW = DW / 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]                   rst;
   logic [1:0][NC-1:0]           req_vld, req_wr, rsp_rdy;
   logic [1:0][NC-1:0][AW-1:0]   req_addr;
   logic [1:0][NC-1:0][DW-1:0]   req_wdata;
   logic [1:0][NC-1:0][BW-1:0]   req_be;

   logic [NC-1:0]         rdy0, rdy1, vld0, vld1, err0, err1;
   logic [NC-1:0][DW-1:0] rdata0, rdata1;

   int n_chk = 0;
   int n_err = 0;

   mem_arb_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(200), .NUM_CH(NC), .RD_LAT(1)) u_dut0 (
      .clk(clk), .rst(rst[0]),
      .req_vld_i(req_vld[0]), .req_wr_i(req_wr[0]), .req_addr_i(req_addr[0]),
      .req_wdata_i(req_wdata[0]), .req_be_i(req_be[0]), .req_rdy_o(rdy0),
      .rsp_vld_o(vld0), .rsp_rdata_o(rdata0), .rsp_err_o(err0), .rsp_rdy_i(rsp_rdy[0])
   );

   mem_arb_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(256), .NUM_CH(NC), .RD_LAT(3)) u_dut1 (
      .clk(clk), .rst(rst[1]),
      .req_vld_i(req_vld[1]), .req_wr_i(req_wr[1]), .req_addr_i(req_addr[1]),
      .req_wdata_i(req_wdata[1]), .req_be_i(req_be[1]), .req_rdy_o(rdy1),
      .rsp_vld_o(vld1), .rsp_rdata_o(rdata1), .rsp_err_o(err1), .rsp_rdy_i(rsp_rdy[1])
   );

   function automatic logic get_rdy(input int u, input int ch);
      return (u == 0) ? rdy0[ch] : rdy1[ch];
   endfunction

   function automatic logic get_vld(input int u, input int ch);
      return (u == 0) ? vld0[ch] : vld1[ch];
   endfunction

   function automatic logic get_err(input int u, input int ch);
      return (u == 0) ? err0[ch] : err1[ch];
   endfunction

   function automatic logic [DW-1:0] get_rdata(input int u, input int ch);
      return (u == 0) ? rdata0[ch] : rdata1[ch];
   endfunction

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Raise a request, wait (bounded) for the grant, return just after the accept edge.
   task automatic issue(input int u, input int ch, input logic wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [BW-1:0] be, input string tag);
      bit ok;
      ok = 1'b0;
      @(negedge clk);
      req_wr[u][ch]    = wr;
      req_addr[u][ch]  = a;
      req_wdata[u][ch] = d;
      req_be[u][ch]    = be;
      req_vld[u][ch]   = 1'b1;
      for (int n = 0; n < 16; n++) begin
         #1;
         if (get_rdy(u, ch)) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (ok) @(posedge clk);
      #1;
      req_vld[u][ch] = 1'b0;
      check({tag, "_grant"}, 32'(ok), 32'd1);
   endtask

   // Called just after an accept edge; lat counts further rising edges until rsp_vld_o.
   task automatic expect_rsp(input int u, input int ch, input int lat, input logic [DW-1:0] exp_d,
                             input logic exp_e, input string tag);
      int seen;
      seen = 0;
      check({tag, "_early"}, 32'(get_vld(u, ch)), 32'd0);
      for (int n = 1; n <= 8; n++) begin
         @(posedge clk);
         #1;
         if (get_vld(u, ch)) begin
            seen = n;
            break;
         end
      end
      check({tag, "_lat"}, 32'(seen), 32'(lat));
      check({tag, "_data"}, 32'(get_rdata(u, ch)), 32'(exp_d));
      check({tag, "_err"}, 32'(get_err(u, ch)), 32'(exp_e));
   endtask

   task automatic ack(input int u, input int ch, input string tag);
      rsp_rdy[u][ch] = 1'b1;
      @(posedge clk);
      #1;
      rsp_rdy[u][ch] = 1'b0;
      check({tag, "_vld_drop"}, 32'(get_vld(u, ch)), 32'd0);
   endtask

   task automatic write(input int u, input int ch, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [BW-1:0] be, input string tag);
      issue(u, ch, 1'b1, a, d, be, tag);
   endtask

   task automatic read(input int u, input int ch, input logic [AW-1:0] a, input logic [DW-1:0] exp_d,
                       input logic exp_e, input int lat, input string tag);
      issue(u, ch, 1'b0, a, '0, '0, tag);
      expect_rsp(u, ch, lat, exp_d, exp_e, tag);
      ack(u, ch, tag);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int bad;
      rst       = 2'b11;
      req_vld   = '1;
      req_wr    = '0;
      req_addr  = '0;
      req_wdata = '0;
      req_be    = '0;
      rsp_rdy   = '0;

      // Reset state: no grant even with requests pending, responses cleared.
      repeat (3) @(posedge clk);
      #1;
      check("rst_rdy0", 32'(rdy0), 32'd0);
      check("rst_rdy1", 32'(rdy1), 32'd0);
      check("rst_vld0", 32'(vld0), 32'd0);
      check("rst_err0", 32'(err0), 32'd0);
      check("rst_rdata0", 32'(rdata0), 32'd0);
      check("rst_vld1", 32'(vld1), 32'd0);
      req_vld = '0;
      @(negedge clk);
      rst = 2'b00;

      // Both channels hold write requests: grants alternate starting at channel 0.
      req_wr[0]       = 2'b11;
      req_addr[0][0]  = 8'h60;
      req_addr[0][1]  = 8'h61;
      req_wdata[0][0] = 16'h6060;
      req_wdata[0][1] = 16'h6161;
      req_be[0]       = '1;
      req_vld[0]      = 2'b11;
      for (int k = 0; k < 6; k++) begin
         #1;
         check($sformatf("rr_gnt%0d", k), 32'(rdy0), (k % 2 == 0) ? 32'd1 : 32'd2);
         @(negedge clk);
      end
      req_vld[0] = '0;
      read(0, 0, 8'h60, 16'h6060, 1'b0, 1, "rr_rd0");
      read(0, 1, 8'h61, 16'h6161, 1'b0, 1, "rr_rd1");

      // Write then read back the cycle after.
      write(0, 0, 8'h10, 16'hBEEF, 2'b11, "t1_wr");
      read(0, 0, 8'h10, 16'hBEEF, 1'b0, 1, "t1_rd");

      // Byte enables merge into the existing word.
      write(0, 0, 8'h05, 16'h1234, 2'b11, "t2_wr0");
      write(0, 0, 8'h05, 16'hAB00, 2'b10, "t2_wr1");
      read(0, 0, 8'h05, 16'hAB34, 1'b0, 1, "t2_rd0");
      write(0, 0, 8'h05, 16'hFFCD, 2'b01, "t2_wr2");
      read(0, 0, 8'h05, 16'hABCD, 1'b0, 1, "t2_rd1");

      // Back-pressured response: held stable, further reads blocked, writes still accepted.
      issue(0, 1, 1'b0, 8'h10, '0, '0, "t4_rd");
      expect_rsp(0, 1, 1, 16'hBEEF, 1'b0, "t4");
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         req_wr[0][1]   = 1'b0;
         req_addr[0][1] = 8'h20;
         req_vld[0][1]  = 1'b1;
         #1;
         check($sformatf("t4_blk_rdy%0d", k), 32'(rdy0[1]), 32'd0);
         check($sformatf("t4_hold_vld%0d", k), 32'(vld0[1]), 32'd1);
         check($sformatf("t4_hold_data%0d", k), 32'(rdata0[1]), 32'hBEEF);
      end
      req_vld[0][1] = 1'b0;
      write(0, 1, 8'h30, 16'h5A5A, 2'b11, "t4_wr");
      check("t4_still_vld", 32'(vld0[1]), 32'd1);
      ack(0, 1, "t4_ack");
      read(0, 1, 8'h30, 16'h5A5A, 1'b0, 1, "t4_rdback");

      // Out-of-range accesses against DEPTH=200.
      write(0, 0, 8'd50, 16'h1111, 2'b11, "t5_wr50");
      write(0, 0, 8'd122, 16'h2222, 2'b11, "t5_wr122");
      write(0, 0, 8'd199, 16'h3333, 2'b11, "t5_wr199");
      read(0, 0, 8'd199, 16'h3333, 1'b0, 1, "t5_rd199");
      read(0, 0, 8'd200, 16'h0000, 1'b1, 1, "t5_rd200");
      read(0, 1, 8'd250, 16'h0000, 1'b1, 1, "t5_rd250");
      write(0, 1, 8'd250, 16'hFFFF, 2'b11, "t5_wr250");
      read(0, 0, 8'd50, 16'h1111, 1'b0, 1, "t5_rd50");
      read(0, 0, 8'd122, 16'h2222, 1'b0, 1, "t5_rd122");
      read(0, 1, 8'd250, 16'h0000, 1'b1, 1, "t5_rd250b");

      // RD_LAT=3 instance: latency, and a write during an in-flight read to the same word.
      write(1, 0, 8'h40, 16'hCAFE, 2'b11, "t6_wr");
      read(1, 0, 8'h40, 16'hCAFE, 1'b0, 3, "t6_rd0");
      issue(1, 0, 1'b0, 8'h40, '0, '0, "t6_rd1");
      write(1, 1, 8'h40, 16'hF00D, 2'b11, "t6_wr_fly");
      expect_rsp(1, 0, 2, 16'hCAFE, 1'b0, "t6_rd1");
      ack(1, 0, "t6_rd1");
      read(1, 1, 8'h40, 16'hF00D, 1'b0, 3, "t6_rd2");

      // Reset one cycle after a read accept discards it; memory survives.
      issue(1, 0, 1'b0, 8'h40, '0, '0, "t6_rd3");
      rst[1] = 1'b1;
      @(posedge clk);
      #1;
      rst[1] = 1'b0;
      bad = 0;
      for (int n = 0; n < 8; n++) begin
         @(posedge clk);
         #1;
         if (vld1 != '0) bad++;
      end
      check("t6_no_rsp", 32'(bad), 32'd0);
      read(1, 0, 8'h40, 16'hF00D, 1'b0, 3, "t6_rd4");

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
